piano_key_scan: RTL and testbench
=================================

Name: piano_key_scan

Overview:
- Upstream front end of the piano path. Takes four raw, bouncy, active-low push-buttons (Do/Re/Mi/Fa).
- Synchronises and debounces each button.
- Emits one single-cycle one-hot `pianos` strobe per confirmed press. The buzzer stage consumes this strobe to start a tone.
- Also exports debounced key levels for LEDs and debug.

Parameters:
- CNT_MAX, 20'd999_999, debounce window in clk cycles minus 1. This is 20 ms at 50 MHz.
- REPEAT_MAX, 32'd24_999_999, auto-repeat period in clk cycles minus 1. This is 500 ms. Used only with KEY_REPEAT_EN.

Ports:
- clk  input  1  system clock, 50 MHz
- rst_n  input  1  asynchronous active-low reset
- key_in  input  4  raw buttons, 0 = pressed; bit0 Do, bit1 Re, bit2 Mi, bit3 Fa
- pianos  output  4  registered one-hot press strobe, 1 cycle wide, 4'd0 when idle
- key_level  output  4  registered debounced state, 1 = held

Behaviour:
- Clocking and reset:
  - Single clock domain `clk`.
  - All flops reset asynchronously on rst_n low.
  - Reset values: synchroniser flops 4'b1111; every FSM in IDLE; all counters 0; pianos 4'd0; key_level 4'd0.
- Synchroniser: two flops per key. The FSM uses only the second stage (`s`).
- Per-key FSM, counter `cnt` of 20 bits:
  - IDLE: if s==0, go to PRESS_FLT with cnt=0.
  - PRESS_FLT:
    - If s==1, go to IDLE and clear cnt (bounce rejected).
    - Else if cnt==CNT_MAX, go to DOWN, set key_level[i]=1 and raise press_req[i] for one cycle.
    - Otherwise cnt+1.
  - DOWN: if s==1, go to REL_FLT with cnt=0.
  - REL_FLT:
    - If s==0, go back to DOWN; no new strobe.
    - Else if cnt==CNT_MAX, go to IDLE and set key_level[i]=0.
    - Otherwise cnt+1.
- Latency:
  - Edge 0 is the first rising clk edge that samples key_in[i] low. key_in is held low from then on.
  - pianos[i] is high only for the cycle after edge CNT_MAX+3.
  - key_level[i] rises at the same edge.
  - Release takes the same CNT_MAX+3 edges to clear key_level.
- A low glitch shorter than CNT_MAX+1 synchronised cycles produces no strobe and no key_level change.
- Output arbitration (registered):
  - pianos is the lowest-index set bit of press_req; otherwise 4'd0.
  - Simultaneous confirmations: only the lowest index is strobed. The others are dropped, though their key_level still rises.
  - pianos is guaranteed one-hot or zero.
- Multiple held keys: each key is independent. A press confirmed while another key is DOWN still strobes.
- Counters never wrap. Each counter saturates at the point where it is consumed by a state change.
- Reset mid-operation: all state is discarded. A key held through reset release is treated as a new press and strobes at edge CNT_MAX+3 after release.

Optional Feature:
- Macro: KEY_REPEAT_EN.
- Defined:
  - Each key has a 32-bit repeat counter, cleared on entry to DOWN.
  - The counter increments while in DOWN.
  - At REPEAT_MAX it clears and raises press_req[i] again, which re-triggers the 500 ms buzzer tone while the key is held.
  - The counter is cleared, and does not advance, in REL_FLT. A bounce back to DOWN resumes from 0.
  - Repeat requests go through the same lowest-index arbitration.
- Not defined:
  - No repeat counter is synthesised.
  - Exactly one strobe is produced per press.

Decomposition:
- Shared package `piano_pkg`:
  - FSM state encoding: IDLE=2'd0, PRESS_FLT=2'd1, DOWN=2'd2, REL_FLT=2'd3.
  - Note one-hot constants: DO=4'b0001, RE=4'b0010, MI=4'b0100, FA=4'b1000. The buzzer stage reuses these.
  - Default CNT_MAX and REPEAT_MAX.
- One sub-module, `key_debounce`:
  - Single key: synchroniser, FSM, counter, optional repeat counter.
  - Outputs press_req and level.
  - Instantiated four times via generate.
  - The top level holds only the arbiter and the output registers.

Test Plan (CNT_MAX=9, REPEAT_MAX=49):
- Clean press: key_in[0] low from edge 0 -> pianos=4'b0001 only in the cycle after edge 12, and key_level[0]=1 from then. Release -> key_level[0]=0 after 12 more edges, with no strobe on release.
- Bounce: key_in[2] toggled low 5 cycles, high 2, low 5, then high -> no strobe, key_level stays 0. Then held low 20 cycles -> single strobe 4'b0100.
- Simultaneous: key_in[1] and key_in[3] driven low on the same edge -> exactly one strobe 4'b0010, and key_level=4'b1010.
- Staggered: Fa held, then Do pressed 30 cycles later -> strobes 4'b1000 then 4'b0001. pianos is never multi-hot.
- Reset mid-filter: rst_n pulsed low at edge 6 of a Mi press with the key still held -> all outputs 0 during reset, then strobe 4'b0100 at edge 12 after rst_n rises.
- KEY_REPEAT_EN: Re held for 200 cycles -> first strobe at edge 12, then repeats every 50 cycles (edges 62, 112, 162). Without the macro -> exactly one strobe.

Source files
------------

// File: rtl/piano_pkg.sv
// piano_pkg: key FSM encoding, note one-hot constants and default timing for the piano front end.
package piano_pkg;
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_FLT = 2'd1,
    DOWN      = 2'd2,
    REL_FLT   = 2'd3
  } key_state_t;
  localparam logic [3:0] DO = 4'b0001;
  localparam logic [3:0] RE = 4'b0010;
  localparam logic [3:0] MI = 4'b0100;
  localparam logic [3:0] FA = 4'b1000;
  localparam logic [19:0] CNT_MAX_DEF = 20'd999_999;
  localparam logic [31:0] REPEAT_MAX_DEF = 32'd24_999_999;
  function automatic logic [3:0] lowest_set(input logic [3:0] v);
    return v & (~v + 4'd1);
  endfunction
endpackage

// File: rtl/key_debounce.sv
// key_debounce: one active-low button, 2-flop synchroniser, debounce FSM, optional auto-repeat.
// Auto-repeat is built only when KEY_REPEAT_EN is defined.
module key_debounce import piano_pkg::*; #(
  parameter logic [19:0] CNT_MAX    = CNT_MAX_DEF,
  parameter logic [31:0] REPEAT_MAX = REPEAT_MAX_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key,
  output logic o_press_req,
  output logic o_level_nxt
);
  logic [1:0] r_sync;
  key_state_t r_state, w_state_nxt;
  logic [19:0] r_cnt, w_cnt_nxt;
  logic w_s, w_confirm;
  assign w_s = r_sync[1];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_sync  <= 2'b11;
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_sync  <= {r_sync[0], i_key};
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_confirm   = 1'b0;
    case (r_state)
      IDLE:
        if (!w_s) begin
          w_state_nxt = PRESS_FLT;
          w_cnt_nxt   = '0;
        end
      PRESS_FLT:
        if (w_s) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_MAX) begin
          w_state_nxt = DOWN;
          w_confirm   = 1'b1;
        end else w_cnt_nxt = r_cnt + 20'd1;
      DOWN:
        if (w_s) begin
          w_state_nxt = REL_FLT;
          w_cnt_nxt   = '0;
        end
      default:
        if (!w_s) w_state_nxt = DOWN;
        else if (r_cnt == CNT_MAX) w_state_nxt = IDLE;
        else w_cnt_nxt = r_cnt + 20'd1;
    endcase
  end
  // Level follows the next state so the top register updates on the confirming edge.
  assign o_level_nxt = w_state_nxt[1];
`ifdef KEY_REPEAT_EN
  logic [31:0] r_rpt;
  logic w_rpt_hit;
  assign w_rpt_hit = (r_state == DOWN) && !w_s && (r_rpt == REPEAT_MAX);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_rpt <= '0;
    else r_rpt <= (r_state == DOWN && !w_s && !w_rpt_hit) ? r_rpt + 32'd1 : '0;
  assign o_press_req = w_confirm | w_rpt_hit;
`else
  logic w_unused_repeat;
  assign w_unused_repeat = ^REPEAT_MAX;
  assign o_press_req = w_confirm;
`endif
endmodule

// File: rtl/piano_key_scan.sv
// piano_key_scan: four debounced piano keys, lowest-index one-hot press strobe plus held levels.
// Define KEY_REPEAT_EN to re-strobe held keys every REPEAT_MAX+1 cycles.
module piano_key_scan import piano_pkg::*; #(
  parameter logic [19:0] CNT_MAX    = CNT_MAX_DEF,
  parameter logic [31:0] REPEAT_MAX = REPEAT_MAX_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_in,
  output logic [3:0] pianos,
  output logic [3:0] key_level
);
  logic [3:0] w_req, w_level_nxt;
  for (genvar i = 0; i < 4; i++) begin : g_key
    key_debounce #(.CNT_MAX(CNT_MAX), .REPEAT_MAX(REPEAT_MAX)) u_key (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_key      (key_in[i]),
      .o_press_req(w_req[i]),
      .o_level_nxt(w_level_nxt[i])
    );
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pianos    <= '0;
      key_level <= '0;
    end else begin
      pianos    <= lowest_set(w_req);
      key_level <= w_level_nxt;
    end
endmodule

// File: tb/tb_piano_key_scan.sv
// tb_piano_key_scan: directed checks of debounce latency, bounce rejection, arbitration and repeat.
module tb_piano_key_scan;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] key_in = 4'hF;
  logic [3:0] pianos, key_level;
  int errors = 0, checks = 0;
`ifdef KEY_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  piano_key_scan #(.CNT_MAX(20'd9), .REPEAT_MAX(32'd49)) dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .pianos(pianos), .key_level(key_level)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_keys;
    key_in = 4'hF;
    repeat (16) step();
    checks++;
    if (key_level !== 4'h0 || pianos !== 4'h0) begin
      errors++;
      $display("FAIL idle_after_release level=%b pianos=%b expected 0000/0000", key_level, pianos);
    end
  endtask

  task automatic test_reset;
    repeat (3) step();
    checks++;
    if (pianos !== 4'h0 || key_level !== 4'h0) begin
      errors++;
      $display("FAIL reset_state pianos=%b level=%b expected 0000/0000", pianos, key_level);
    end
    rst_n = 1'b1;
    repeat (4) step();
    checks++;
    if (pianos !== 4'h0 || key_level !== 4'h0) begin
      errors++;
      $display("FAIL post_reset_idle pianos=%b level=%b expected 0000/0000", pianos, key_level);
    end
  endtask

  task automatic test_clean_press;
    key_in[0] = 1'b0;
    for (int e = 0; e <= 25; e++) begin
      step();
      checks++;
      if (pianos !== (e == 12 ? 4'b0001 : 4'b0000) || key_level !== (e >= 12 ? 4'b0001 : 4'b0000)) begin
        errors++;
        $display("FAIL clean_press e=%0d pianos=%b level=%b expected %b/%b", e, pianos, key_level,
                 (e == 12 ? 4'b0001 : 4'b0000), (e >= 12 ? 4'b0001 : 4'b0000));
      end
    end
    key_in[0] = 1'b1;
    for (int e = 0; e <= 20; e++) begin
      step();
      checks++;
      if (pianos !== 4'b0000 || key_level !== (e < 12 ? 4'b0001 : 4'b0000)) begin
        errors++;
        $display("FAIL clean_release e=%0d pianos=%b level=%b expected 0000/%b", e, pianos, key_level,
                 (e < 12 ? 4'b0001 : 4'b0000));
      end
    end
  endtask

  task automatic test_bounce;
    for (int e = 0; e < 27; e++) begin
      key_in[2] = (e < 5 || (e >= 7 && e < 12)) ? 1'b0 : 1'b1;
      step();
      checks++;
      if (pianos !== 4'h0 || key_level !== 4'h0) begin
        errors++;
        $display("FAIL bounce_reject e=%0d pianos=%b level=%b expected 0000/0000", e, pianos, key_level);
      end
    end
    key_in[2] = 1'b0;
    for (int e = 0; e < 20; e++) begin
      step();
      checks++;
      if (pianos !== (e == 12 ? 4'b0100 : 4'b0000) || key_level !== (e >= 12 ? 4'b0100 : 4'b0000)) begin
        errors++;
        $display("FAIL bounce_hold e=%0d pianos=%b level=%b", e, pianos, key_level);
      end
    end
    idle_keys();
  endtask

  task automatic test_simultaneous;
    key_in = 4'b0101;
    for (int e = 0; e <= 20; e++) begin
      step();
      checks++;
      if (pianos !== (e == 12 ? 4'b0010 : 4'b0000) || key_level !== (e >= 12 ? 4'b1010 : 4'b0000)) begin
        errors++;
        $display("FAIL simultaneous e=%0d pianos=%b level=%b", e, pianos, key_level);
      end
    end
    idle_keys();
  endtask

  task automatic test_staggered;
    logic [3:0] exp_p, exp_l;
    key_in[3] = 1'b0;
    for (int e = 0; e <= 55; e++) begin
      if (e == 30) key_in[0] = 1'b0;
      step();
      exp_p = (e == 12) ? 4'b1000 : (e == 42) ? 4'b0001 : 4'b0000;
      exp_l = {e >= 12, 2'b00, e >= 42};
      checks++;
      if (pianos !== exp_p || key_level !== exp_l || !$onehot0(pianos)) begin
        errors++;
        $display("FAIL staggered e=%0d pianos=%b level=%b expected %b/%b", e, pianos, key_level, exp_p, exp_l);
      end
    end
    idle_keys();
  endtask

  task automatic test_reset_mid_filter;
    key_in[2] = 1'b0;
    repeat (7) step();
    rst_n = 1'b0;
    #1;
    checks++;
    if (pianos !== 4'h0 || key_level !== 4'h0) begin
      errors++;
      $display("FAIL reset_mid_async pianos=%b level=%b expected 0000/0000", pianos, key_level);
    end
    repeat (3) step();
    checks++;
    if (pianos !== 4'h0 || key_level !== 4'h0) begin
      errors++;
      $display("FAIL reset_mid_hold pianos=%b level=%b expected 0000/0000", pianos, key_level);
    end
    rst_n = 1'b1;
    for (int e = 0; e <= 20; e++) begin
      step();
      checks++;
      if (pianos !== (e == 12 ? 4'b0100 : 4'b0000) || key_level !== (e >= 12 ? 4'b0100 : 4'b0000)) begin
        errors++;
        $display("FAIL reset_mid_restart e=%0d pianos=%b level=%b", e, pianos, key_level);
      end
    end
    idle_keys();
  endtask

  task automatic test_repeat;
    logic [3:0] exp_p;
    key_in[1] = 1'b0;
    for (int e = 0; e < 200; e++) begin
      step();
      exp_p = (e == 12 || (REP && e > 12 && (e - 12) % 50 == 0)) ? 4'b0010 : 4'b0000;
      checks++;
      if (pianos !== exp_p) begin
        errors++;
        $display("FAIL repeat e=%0d pianos=%b expected %b", e, pianos, exp_p);
      end
    end
    key_in[1] = 1'b1;
    for (int e = 0; e < 20; e++) begin
      step();
      checks++;
      if (pianos !== 4'h0) begin
        errors++;
        $display("FAIL repeat_release e=%0d pianos=%b expected 0000", e, pianos);
      end
    end
    idle_keys();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_staggered();
    test_reset_mid_filter();
    test_repeat();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
